async_join_rx: RTL and testbench
================================

// Module: async_join_rx
// PURPOSE
//  Clocked receiver for the 4-phase bundled-data channel produced by a 3-input join
//  (its req_out / ack_out pair). Synchronises req, captures the bundled data word,
//  returns ack, and buffers words in a FIFO.
//  Words are presented on a valid/ready interface to synchronous pipeline logic.
// PARAMETERS
//  DATA_W       32  width of bundled data word
//  DEPTH        4   FIFO entries; power of 2, >= 2
//  SYNC_STAGES  2   req synchroniser flops; >= 2
// PORTS
//  clk_i    in   1                   clock
//  rst_ni   in   1                   reset, asynchronous, active-low
//  req_i    in   1                   4-phase request from join req_out (asynchronous)
//  ack_o    out  1                   4-phase acknowledge to join ack_out
//  data_i   in   DATA_W              bundled data; sender holds stable from req_i rise until ack_o rise
//  valid_o  out  1                   FIFO head valid
//  ready_i  in   1                   consumer accepts head when valid_o & ready_i
//  data_o   out  DATA_W              FIFO head word
//  count_o  out  $clog2(DEPTH+1)     current occupancy
//  err_o    out  1                   sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_ni=0, async): ack_o=0, valid_o=0, count_o=0, err_o=0, data_o=0, sync flops=0,
//    state=IDLE, pointers=0. Takes effect immediately, without waiting for a clock edge.
//  - req_s = last flop of SYNC_STAGES-deep chain on req_i; ack_o driven straight from a flop.
//  - FSM, 2 states:
//    IDLE (ack_o=0): req_s=1 & !full -> write data_i at wr_ptr, ack_o<=1, -> WAIT_LOW.
//      req_s=1 & full -> stay IDLE, no write (backpressure; sender waits).
//    WAIT_LOW (ack_o=1): req_s=0 -> ack_o<=0, -> IDLE. No write in this state.
//  - Latency: req_i rises before edge 1 -> ack_o high after edge SYNC_STAGES+1.
//    Written word visible on data_o with valid_o=1 after the same edge if FIFO was empty.
//    req_i falls -> ack_o low SYNC_STAGES+1 edges later.
//  - FIFO: show-ahead; data_o = mem[rd_ptr]; valid_o = (count_o != 0).
//    Pop on valid_o & ready_i; ready_i with valid_o=0 is ignored.
//    Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
//  - Simultaneous push and pop: count_o unchanged; FIFO order preserved.
//  - Full decision uses registered count: no push when count_o==DEPTH, even with a pop
//    in the same cycle. The push happens on the next edge.
//  - Exactly one word is written per 4-phase cycle; req_s staying high in WAIT_LOW
//    never causes a second write.
//  - Reset mid-handshake: ack_o drops at once and captured words are lost. The join
//    upstream shares the same reset source.
// CONFIGURATION
//  ASYNC_RX_PROTO_CHK_EN defined:
//    - In IDLE, req_s falling 1->0 (request withdrawn before ack) sets err_o=1.
//    - err_o is sticky until reset. The FSM itself is unaffected.
//  ASYNC_RX_PROTO_CHK_EN undefined:
//    - err_o tied to 0 and no check logic is built. The port list is identical either way.
// TESTING (DATA_W=32, DEPTH=4, SYNC_STAGES=2)
//  1. rst_ni=0 with req_i=1 -> ack_o=0, valid_o=0, count_o=0, err_o=0 with no clock edge.
//  2. req_i=1, data_i=32'hDEADBEEF before edge 1, ready_i=0:
//     -> after edge 3: ack_o=1, valid_o=1, data_o=DEADBEEF, count_o=1.
//     Then req_i=0 -> ack_o=0 three edges later.
//  3. ready_i=0, four handshakes of 1..4 -> count_o=4. Fifth req_i=1 -> ack_o stays 0.
//     ready_i=1 for one cycle pops 1; fifth word is accepted on the following edge.
//  4. count_o=2, push and pop on the same edge -> count_o stays 2; pop order 1,2,3 intact.
//  5. rst_ni asserted while ack_o=1 -> ack_o=0, count_o=0 immediately.
//     After release with req_i=0 -> FSM in IDLE.
//  6. Macro defined: FIFO full, req_i raised then dropped without ack -> err_o=1, held for 10 cycles.
//     Cleared only by reset. Macro undefined: err_o=0 throughout.

Source files
------------

// File: rtl/async_join_rx.sv
// Clocked receiver for a 4-phase bundled-data join channel: req synchroniser, ack FSM, show-ahead FIFO.
// Optional protocol checker enabled by defining ASYNC_RX_PROTO_CHK_EN (err_o tied low otherwise).
module async_join_rx #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  output logic                       ack_o,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, WAIT_LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  state_t                 state_q;
  logic                   ack_q;
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic                   full;
  logic                   push;
  logic                   pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Full is judged on the registered count so a same-edge pop never makes room early.
  assign full = (count_q == CW'(DEPTH));
  assign push = (state_q == IDLE) && req_s && !full;
  assign pop  = (count_q != '0) && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            ack_q   <= 1'b1;
            state_q <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign ack_o   = ack_q;
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifdef ASYNC_RX_PROTO_CHK_EN
  logic req_s_prev_q;
  logic err_q;

  // A request that falls while still un-acknowledged was withdrawn by the sender.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_s_prev_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      req_s_prev_q <= req_s;
      if ((state_q == IDLE) && req_s_prev_q && !req_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_async_join_rx.sv
// Bench for async_join_rx: directed handshake scenarios plus randomized traffic,
// with a queue scoreboard checked by an independent monitor on every pop.
module tb_async_join_rx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk;
  logic              rst_ni;
  logic              req_i;
  logic              ack_o;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CW-1:0]     count_o;
  logic              err_o;

  logic [DATA_W-1:0] exp_q[$];
  int                n_checks;
  int                n_pass;
  logic              exp_err;
  bit                rand_done;

  async_join_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .ack_o  (ack_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .count_o(count_o),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // Checks land at posedge+1, stimulus changes at posedge+2, the monitor samples at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted head must be the oldest word the bench has seen acknowledged.
  always @(negedge clk) begin
    if (rst_ni && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected_pop: got %h expected no word", data_o);
      end else begin
        check("sb_data", data_o, exp_q.pop_front());
      end
    end
  end

  task automatic handshake(input logic [31:0] d);
    int n;
    data_i = d;
    req_i  = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ack_o && n < 300);
    check("hs_ack_rise", {31'b0, ack_o}, 32'd1);
    if (ack_o) exp_q.push_back(d);
    #1 req_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ack_o && n < 20);
    check("hs_ack_fall", {31'b0, ack_o}, 32'd0);
    #1;
  endtask

  task automatic drain();
    int n;
    ready_i = 1'b1;
    n = 0;
    do begin tick(); n++; end while (count_o != 0 && n < 20);
    check("drain_count", 32'(count_o), 32'd0);
    #1 ready_i = 1'b0;
  endtask

  task automatic apply_reset();
    #1 rst_ni = 1'b0;
    #1;
    check("rst_ack", {31'b0, ack_o}, 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    exp_q.delete();
    req_i = 1'b0;
    tick(); tick();
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
`ifdef ASYNC_RX_PROTO_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_ni  = 1'b1;
    req_i   = 1'b1;
    ready_i = 1'b0;
    data_i  = '0;

    // Reset with req high, before any clock edge
    #2 rst_ni = 1'b0;
    #1;
    check("t1_ack", {31'b0, ack_o}, 32'd0);
    check("t1_valid", {31'b0, valid_o}, 32'd0);
    check("t1_count", 32'(count_o), 32'd0);
    check("t1_err", {31'b0, err_o}, 32'd0);
    check("t1_data", data_o, 32'd0);
    req_i = 1'b0;
    repeat (3) tick();
    #1 rst_ni = 1'b1;
    tick();
    #1;

    // Latency of ack and of the first word
    data_i = 32'hDEADBEEF;
    req_i  = 1'b1;
    tick(); check("t2_ack_e1", {31'b0, ack_o}, 32'd0);
    tick(); check("t2_ack_e2", {31'b0, ack_o}, 32'd0);
    check("t2_valid_e2", {31'b0, valid_o}, 32'd0);
    tick();
    check("t2_ack_e3", {31'b0, ack_o}, 32'd1);
    check("t2_valid_e3", {31'b0, valid_o}, 32'd1);
    check("t2_data_e3", data_o, 32'hDEADBEEF);
    check("t2_count_e3", 32'(count_o), 32'd1);
    exp_q.push_back(32'hDEADBEEF);
    #1 req_i = 1'b0;
    tick(); check("t2_fall_e1", {31'b0, ack_o}, 32'd1);
    tick(); check("t2_fall_e2", {31'b0, ack_o}, 32'd1);
    tick(); check("t2_fall_e3", {31'b0, ack_o}, 32'd0);
    check("t2_count_hold", 32'(count_o), 32'd1);
    drain();

    // Fill, backpressure, single pop then deferred push
    for (int i = 1; i <= 4; i++) handshake(32'(i));
    check("t3_count_full", 32'(count_o), 32'd4);
    check("t3_err_clean", {31'b0, err_o}, 32'd0);
    data_i = 32'd5;
    req_i  = 1'b1;
    repeat (6) tick();
    check("t3_bp_ack", {31'b0, ack_o}, 32'd0);
    check("t3_bp_count", 32'(count_o), 32'd4);
    #1 ready_i = 1'b1;
    tick();
    check("t3_pop_ack", {31'b0, ack_o}, 32'd0);
    check("t3_pop_count", 32'(count_o), 32'd3);
    #1 ready_i = 1'b0;
    tick();
    check("t3_late_ack", {31'b0, ack_o}, 32'd1);
    check("t3_late_count", 32'(count_o), 32'd4);
    exp_q.push_back(32'd5);
    #1 req_i = 1'b0;
    repeat (3) tick();
    check("t3_ack_low", {31'b0, ack_o}, 32'd0);

    // Simultaneous push and pop at occupancy 2
    #1 ready_i = 1'b1;
    tick(); tick();
    #1 ready_i = 1'b0;
    check("t4_count2", 32'(count_o), 32'd2);
    data_i = 32'd6;
    req_i  = 1'b1;
    tick(); tick();
    #1 ready_i = 1'b1;
    tick();
    check("t4_ack", {31'b0, ack_o}, 32'd1);
    check("t4_count_same", 32'(count_o), 32'd2);
    exp_q.push_back(32'd6);
    #1 ready_i = 1'b0;
    req_i = 1'b0;
    repeat (3) tick();
    check("t4_ack_low", {31'b0, ack_o}, 32'd0);
    #1;
    drain();
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a handshake
    #1 data_i = 32'd7;
    req_i = 1'b1;
    repeat (3) tick();
    check("t5_ack_before", {31'b0, ack_o}, 32'd1);
    apply_reset();
    repeat (3) tick();
    check("t5_idle_ack", {31'b0, ack_o}, 32'd0);
    check("t5_idle_count", 32'(count_o), 32'd0);
    #1;
    handshake(32'd8);
    check("t5_count_after", 32'(count_o), 32'd1);
    drain();

    // Request withdrawn while blocked by a full FIFO
    #1;
    for (int i = 11; i <= 14; i++) handshake(32'(i));
    data_i = 32'd15;
    req_i  = 1'b1;
    repeat (4) tick();
    check("t6_err_pre", {31'b0, err_o}, 32'd0);
    #1 req_i = 1'b0;
    repeat (4) tick();
    check("t6_ack", {31'b0, ack_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("t6_err_hold", {31'b0, err_o}, {31'b0, exp_err});
      tick();
    end
    apply_reset();
    tick();
    #1;

    // Randomized traffic against the queue model
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          #1;
          handshake($urandom);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          #1 ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    check("rand_err", {31'b0, err_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
